// File: rtl/alu.sv
// 16-bit registered ALU: add/sub, bitwise logic, even parity, compares, pass-B.
// Define ALU_SHIFT_EN to build the SLL/SRL/SRA shifter on opcodes 7-9; otherwise they read as reserved.
module alu (
  input  logic        clock,
  input  logic [15:0] input_a,
  input  logic [15:0] input_b,
  output logic [15:0] out,
  input  logic [3:0]  op,
  input  logic        reset_n
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_EPAR  = 4'd4,
    OP_XOR   = 4'd5,
    OP_NOT   = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_SLT   = 4'd10,
    OP_SLTU  = 4'd11,
    OP_PASSB = 4'd12
  } op_e;

  logic [15:0] result;

`ifdef ALU_SHIFT_EN
  // Only the low nibble of B is the shift amount; the upper bits are ignored.
  logic [3:0] shamt;
  assign shamt = input_b[3:0];
`endif

  always_comb begin
    // NOTE: result gets a default before the case, so every opcode (including
    // the reserved ones) assigns it and no latch is inferred.
    result = '0;
    case (op)
      OP_ADD:   result = input_a + input_b;
      OP_SUB:   result = input_a - input_b;
      OP_AND:   result = input_a & input_b;
      OP_OR:    result = input_a | input_b;
      // Bit 0 is the parity slot, so parity covers A[15:1] only.
      OP_EPAR:  result = {15'b0, ^input_a[15:1]};
      OP_XOR:   result = input_a ^ input_b;
      OP_NOT:   result = ~input_a;
`ifdef ALU_SHIFT_EN
      OP_SLL:   result = input_a << shamt;
      OP_SRL:   result = input_a >> shamt;
      OP_SRA:   result = $signed(input_a) >>> shamt;
`endif
      OP_SLT:   result = {15'b0, $signed(input_a) < $signed(input_b)};
      OP_SLTU:  result = {15'b0, input_a < input_b};
      OP_PASSB: result = input_b;
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_n) out <= '0;
    else          out <= result;
  end

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu against an arithmetic reference model.
// Honours ALU_SHIFT_EN the same way the design does.
module tb_alu;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] input_a, input_b, out;
  logic [3:0]  op;

  int n_checks = 0;
  int n_errors = 0;

  alu dut (
    .clock   (clock),
    .input_a (input_a),
    .input_b (input_b),
    .out     (out),
    .op      (op),
    .reset_n (reset_n)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model from the opcode rules, using integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] code);
    int sa, sb, d, q, ones;
    logic [15:0] r;
    sa = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
    d  = 1 << (int'(b) % 16);
    ones = 0;
    for (int i = 1; i < 16; i++) ones += int'(a[i]);
    case (code)
      4'd0:  r = 16'((int'(a) + int'(b)) % 65536);
      4'd1:  r = 16'((int'(a) - int'(b) + 65536) % 65536);
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = 16'(ones % 2);
      4'd5:  r = a ^ b;
      4'd6:  r = 16'(65535 - int'(a));
`ifdef ALU_SHIFT_EN
      4'd7:  r = 16'((int'(a) * d) % 65536);
      4'd8:  r = 16'(int'(a) / d);
      4'd9:  begin
        q = sa / d;
        if (sa < 0 && (sa % d) != 0) q = q - 1;
        r = 16'(q);
      end
`endif
      4'd10: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd11: r = (int'(a) < int'(b)) ? 16'd1 : 16'd0;
      4'd12: r = b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  code;
    logic [15:0] exp;
    string       tag;
  } vec_t;

  logic [15:0] last_exp;

  // Drive at the falling edge, confirm out has not moved, then check one edge later.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [3:0] code,
                       input logic [15:0] exp, input string tag);
    @(negedge clock);
    input_a = a;
    input_b = b;
    op      = code;
    #1;
    check({tag, "_hold"}, out, last_exp);
    @(posedge clock);
    #1;
    check(tag, out, exp);
    last_exp = exp;
  endtask

  vec_t vecs[$];

  initial begin
    reset_n = 1'b0;
    input_a = 16'd5;
    input_b = 16'd3;
    op      = 4'd0;
    #1;
    check("reset_async", out, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    check("reset_hold", out, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset_release_pre_edge", out, 16'h0000);
    @(posedge clock);
    #1;
    check("reset_first_capture", out, 16'd8);
    last_exp = 16'd8;

    vecs.push_back('{16'd1,    16'd1,    4'd0,  16'd2,    "add_1_1"});
    vecs.push_back('{16'hFFFF, 16'd1,    4'd0,  16'h0000, "add_wrap"});
    vecs.push_back('{16'd1,    16'd0,    4'd1,  16'd1,    "sub_1_0"});
    vecs.push_back('{16'd1,    16'd1,    4'd1,  16'd0,    "sub_1_1"});
    vecs.push_back('{16'd0,    16'd1,    4'd1,  16'hFFFF, "sub_wrap"});
    vecs.push_back('{16'd1,    16'd0,    4'd2,  16'd0,    "and_1_0"});
    vecs.push_back('{16'd1,    16'd1,    4'd2,  16'd1,    "and_1_1"});
    vecs.push_back('{16'd0,    16'd1,    4'd3,  16'd1,    "or_0_1"});
    vecs.push_back('{16'd0,    16'd0,    4'd3,  16'd0,    "or_0_0"});
    vecs.push_back('{16'h00FF, 16'h0F0F, 4'd5,  16'h0FF0, "xor"});
    vecs.push_back('{16'h00FF, 16'hABCD, 4'd6,  16'hFF00, "not"});
    vecs.push_back('{16'd2,    16'hBEEF, 4'd4,  16'd1,    "epar_2"});
    vecs.push_back('{16'd1,    16'h1234, 4'd4,  16'd0,    "epar_1"});
    vecs.push_back('{16'h0006, 16'hFFFF, 4'd4,  16'd0,    "epar_6"});
    vecs.push_back('{16'hFFFF, 16'd1,    4'd10, 16'd1,    "slt"});
    vecs.push_back('{16'hFFFF, 16'd1,    4'd11, 16'd0,    "sltu"});
    vecs.push_back('{16'h5555, 16'h1234, 4'd12, 16'h1234, "passb"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 4'd15, 16'h0000, "op15"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 4'd13, 16'h0000, "op13"});
`ifdef ALU_SHIFT_EN
    vecs.push_back('{16'h8001, 16'h0011, 4'd7,  16'h0002, "sll"});
    vecs.push_back('{16'h8001, 16'h0011, 4'd8,  16'h4000, "srl"});
    vecs.push_back('{16'h8001, 16'h0011, 4'd9,  16'hC000, "sra"});
    vecs.push_back('{16'h8001, 16'h0030, 4'd9,  16'h8001, "sra_amt0"});
`else
    vecs.push_back('{16'h8001, 16'h0011, 4'd7,  16'h0000, "sll_off"});
    vecs.push_back('{16'h8001, 16'h0011, 4'd8,  16'h0000, "srl_off"});
    vecs.push_back('{16'h8001, 16'h0011, 4'd9,  16'h0000, "sra_off"});
`endif

    foreach (vecs[i]) apply(vecs[i].a, vecs[i].b, vecs[i].code, vecs[i].exp, vecs[i].tag);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      logic [3:0]  code;
      a    = 16'($urandom);
      b    = 16'($urandom);
      code = 4'($urandom_range(0, 15));
      if (i % 8 == 0) b = 16'($urandom_range(0, 3));
      apply(a, b, code, model(a, b, code), $sformatf("rand_op%0d", code));
    end

    // Reset asserted between edges discards the pending result immediately.
    @(negedge clock);
    input_a = 16'h1111;
    input_b = 16'h2222;
    op      = 4'd0;
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_op", out, 16'h0000);
    @(posedge clock);
    #1;
    check("reset_mid_op_edge", out, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("reset_recover", out, 16'h3333);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
